// File: rtl/mem_compare_pipe_if.sv
// Bus bundle for mem_compare_pipe: command, shared memory read port, and status.
// The slave modport is the comparator's view; master is the requester/memory side.
// Optional first-mismatch reporting is present when MEM_COMPARE_FIRST_MISMATCH_EN is defined.
interface mem_compare_pipe_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             i_start;
    logic [AW-1:0]    i_start_addr;
    logic [AW-1:0]    i_end_addr;
    logic [WIDTH-1:0] i_last_mask;
    logic [AW-1:0]    o_mem_in_addr;
    logic             o_mem_in_en;
    logic [WIDTH-1:0] i_mem_in_1;
    logic [WIDTH-1:0] i_mem_in_2;
    logic             o_busy;
    logic             o_fail;
    logic             o_done;
`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
    logic [AW-1:0]    o_mismatch_addr;
    logic             o_mismatch_vld;
`endif

    modport slave (
        input  i_start,
        input  i_start_addr,
        input  i_end_addr,
        input  i_last_mask,
        output o_mem_in_addr,
        output o_mem_in_en,
        input  i_mem_in_1,
        input  i_mem_in_2,
        output o_busy,
        output o_fail,
`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
        output o_mismatch_addr,
        output o_mismatch_vld,
`endif
        output o_done
    );

    modport master (
        output i_start,
        output i_start_addr,
        output i_end_addr,
        output i_last_mask,
        input  o_mem_in_addr,
        input  o_mem_in_en,
        output i_mem_in_1,
        output i_mem_in_2,
        input  o_busy,
        input  o_fail,
`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
        input  o_mismatch_addr,
        input  o_mismatch_vld,
`endif
        input  o_done
    );
endinterface

// File: rtl/mem_compare_pipe.sv
// mem_compare_pipe: constant-time compare of an address range in two memories.
// Issues one read per cycle to both memories, tags each read through an RD_LAT-deep
// valid/last pipeline, and folds masked XOR differences into a sticky fail flag.
// Optional feature: define MEM_COMPARE_FIRST_MISMATCH_EN to report the first
// mismatching address on o_mismatch_addr / o_mismatch_vld.
module mem_compare_pipe #(
    parameter int WIDTH         = 32,
    parameter int MAX_MEM_DEPTH = 16,
    parameter int RD_LAT        = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_compare_pipe_if.slave  bus
);
    localparam int AW = (MAX_MEM_DEPTH > 1) ? $clog2(MAX_MEM_DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [AW-1:0]     r_addr;
    logic [AW-1:0]     r_end_addr;
    logic [WIDTH-1:0]  r_mask;
    logic [RD_LAT-1:0] r_vld_pipe;
    logic [RD_LAT-1:0] r_last_pipe;
    logic              r_acc;
    logic              r_busy;
    logic              r_fail;
    logic              r_done;

    logic              w_start;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_cmp_vld;
    logic              w_cmp_last;
    logic [WIDTH-1:0]  w_mask;
    logic [WIDTH-1:0]  w_term;
    logic              w_term_any;

    assign w_start      = (r_state == S_IDLE) && bus.i_start;
    assign w_issue      = (r_state == S_ISSUE);
    assign w_issue_last = w_issue && (r_addr == r_end_addr);
    assign w_cmp_vld    = r_vld_pipe[RD_LAT-1];
    assign w_cmp_last   = r_last_pipe[RD_LAT-1];
    assign w_mask       = w_cmp_last ? r_mask : {WIDTH{1'b1}};
    assign w_term       = (bus.i_mem_in_1 ^ bus.i_mem_in_2) & w_mask;
    assign w_term_any   = |w_term;

    assign bus.o_mem_in_addr = r_addr;
    assign bus.o_mem_in_en   = w_issue;
    assign bus.o_busy        = r_busy;
    assign bus.o_fail        = r_fail;
    assign bus.o_done        = r_done;

    // Sequencer: accept a request, walk the address range, wait for the last tagged read.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_end_addr <= '0;
            r_mask     <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here see pre-edge values,
            // so statement order inside this block never changes behaviour.
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_addr     <= bus.i_start_addr;
                        r_end_addr <= bus.i_end_addr;
                        r_mask     <= bus.i_last_mask;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Compare against the end address so the range wraps through 0.
                    if (w_issue_last) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_cmp_vld && w_cmp_last) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Read tag pipeline: marks which cycles carry valid data and which one is the last word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe[0]  <= w_issue;
            r_last_pipe[0] <= w_issue_last;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i]  <= r_vld_pipe[i-1];
                r_last_pipe[i] <= r_last_pipe[i-1];
            end
        end
    end

    // Result accumulation: sticky mismatch flag, no early exit, fail/done on the last compare.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc  <= 1'b0;
            r_busy <= 1'b0;
            r_fail <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_acc  <= 1'b0;
                r_fail <= 1'b0;
                r_busy <= 1'b1;
            end else if (w_cmp_vld) begin
                if (w_cmp_last) begin
                    r_fail <= r_acc | w_term_any;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_acc  <= 1'b0;
                end else begin
                    r_acc <= r_acc | w_term_any;
                end
            end
        end
    end

`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
    logic [AW-1:0] r_tag_pipe [RD_LAT];
    logic [AW-1:0] r_mm_addr;
    logic          r_mm_vld;

    assign bus.o_mismatch_addr = r_mm_addr;
    assign bus.o_mismatch_vld  = r_mm_vld;

    // Address tags travel alongside the valid pipeline to name the word being compared.
    // NOTE: these tags are pure data qualified by r_vld_pipe, so they carry no reset.
    always_ff @(posedge i_clk) begin
        r_tag_pipe[0] <= r_addr;
        for (int i = 1; i < RD_LAT; i++) begin
            r_tag_pipe[i] <= r_tag_pipe[i-1];
        end
    end

    // First-mismatch capture: the earliest nonzero compare term wins and is never overwritten.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mm_addr <= '0;
            r_mm_vld  <= 1'b0;
        end else if (w_start) begin
            r_mm_addr <= '0;
            r_mm_vld  <= 1'b0;
        end else if (w_cmp_vld && w_term_any && !r_mm_vld) begin
            r_mm_addr <= r_tag_pipe[RD_LAT-1];
            r_mm_vld  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_compare_pipe.sv
// Testbench for mem_compare_pipe: two instances (RD_LAT=1 and RD_LAT=3) run the same
// requests side by side against behavioural memories; a scoreboard of expected
// fail/latency/first-mismatch results is filled at request time and drained on o_done.
module tb_mem_compare_pipe;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct {
        logic          fail;
        int            lat;
        logic          mm_vld;
        logic [AW-1:0] mm_addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   chk_total = 0;
    int   chk_pass  = 0;

    logic [WIDTH-1:0] mem1 [DEPTH];
    logic [WIDTH-1:0] mem2 [DEPTH];
    exp_t             sb1[$];
    exp_t             sb3[$];
    logic [AW-1:0]    seen1[$];
    logic [AW-1:0]    seen3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_compare_pipe_if #(.WIDTH(WIDTH), .AW(AW)) bus1 ();
    mem_compare_pipe_if #(.WIDTH(WIDTH), .AW(AW)) bus3 ();

    mem_compare_pipe #(.WIDTH(WIDTH), .MAX_MEM_DEPTH(DEPTH), .RD_LAT(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1)
    );

    mem_compare_pipe #(.WIDTH(WIDTH), .MAX_MEM_DEPTH(DEPTH), .RD_LAT(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3)
    );

    // Behavioural memories with 1 and 3 cycle read latency; unenabled cycles return
    // differing filler so a misaligned compare shows up as a mismatch.
    logic [WIDTH-1:0] p1_a, p1_b;
    logic [WIDTH-1:0] p3_a [3];
    logic [WIDTH-1:0] p3_b [3];
    always @(posedge clk) begin
        p1_a    <= bus1.o_mem_in_en ? mem1[bus1.o_mem_in_addr] : '0;
        p1_b    <= bus1.o_mem_in_en ? mem2[bus1.o_mem_in_addr] : '1;
        p3_a[0] <= bus3.o_mem_in_en ? mem1[bus3.o_mem_in_addr] : '0;
        p3_b[0] <= bus3.o_mem_in_en ? mem2[bus3.o_mem_in_addr] : '1;
        p3_a[1] <= p3_a[0];
        p3_b[1] <= p3_b[0];
        p3_a[2] <= p3_a[1];
        p3_b[2] <= p3_b[1];
    end
    assign bus1.i_mem_in_1 = p1_a;
    assign bus1.i_mem_in_2 = p1_b;
    assign bus3.i_mem_in_1 = p3_a[2];
    assign bus3.i_mem_in_2 = p3_b[2];

    // Record every issued address.
    always @(negedge clk) begin
        if (bus1.o_mem_in_en) seen1.push_back(bus1.o_mem_in_addr);
        if (bus3.o_mem_in_en) seen3.push_back(bus3.o_mem_in_addr);
    end

    task automatic drive_req(input logic s, input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                             input logic [WIDTH-1:0] m);
        bus1.i_start = s; bus1.i_start_addr = sa; bus1.i_end_addr = ea; bus1.i_last_mask = m;
        bus3.i_start = s; bus3.i_start_addr = sa; bus3.i_end_addr = ea; bus3.i_last_mask = m;
    endtask

    task automatic fill_equal();
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] = $urandom;
            mem2[i] = mem1[i];
        end
    endtask

    // One complete request on both instances, with optional start pulse while busy.
    task automatic run_op(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                          input logic [WIDTH-1:0] mask, input bit inject);
        int            n;
        int            c0;
        bit            got1, got3;
        exp_t          e, x;
        logic [AW-1:0] a;
        logic [WIDTH-1:0] term;
        logic [AW-1:0] exp_addr[$];

        n = int'(AW'(ea - sa)) + 1;
        e.fail = 1'b0; e.mm_vld = 1'b0; e.mm_addr = '0;
        for (int i = 0; i < n; i++) begin
            a = AW'(sa + AW'(i));
            exp_addr.push_back(a);
            term = (mem1[a] ^ mem2[a]) & ((i == n - 1) ? mask : '1);
            if (term != '0) begin
                e.fail = 1'b1;
                if (!e.mm_vld) begin
                    e.mm_vld  = 1'b1;
                    e.mm_addr = a;
                end
            end
        end
        e.lat = n + 1; sb1.push_back(e);
        e.lat = n + 3; sb3.push_back(e);
        seen1.delete();
        seen3.delete();

        @(negedge clk);
        drive_req(1'b1, sa, ea, mask);
        @(posedge clk);
        #1 c0 = cyc;
        @(negedge clk);
        drive_req(1'b0, sa, ea, mask);
        chk_total++;
        if (bus1.o_busy !== 1'b1) $display("FAIL busy1_after_start: got %b expected 1", bus1.o_busy);
        else chk_pass++;
        chk_total++;
        if (bus3.o_busy !== 1'b1) $display("FAIL busy3_after_start: got %b expected 1", bus3.o_busy);
        else chk_pass++;

        got1 = 1'b0;
        got3 = 1'b0;
        for (int k = 0; k < 60 && !(got1 && got3); k++) begin
            if (k > 0) @(negedge clk);
            if (inject && k == 1) drive_req(1'b1, sa + 4'd7, sa + 4'd7, '0);
            if (inject && k == 2) drive_req(1'b0, sa, ea, mask);
            if (bus1.o_done === 1'b1 && !got1) begin
                got1 = 1'b1;
                x = sb1.pop_front();
                chk_total++;
                if (cyc - c0 !== x.lat) $display("FAIL lat1: got %0d expected %0d", cyc - c0, x.lat);
                else chk_pass++;
                chk_total++;
                if (bus1.o_fail !== x.fail) $display("FAIL fail1: got %b expected %b", bus1.o_fail, x.fail);
                else chk_pass++;
                chk_total++;
                if (bus1.o_busy !== 1'b0) $display("FAIL busy1_at_done: got %b expected 0", bus1.o_busy);
                else chk_pass++;
`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
                chk_total++;
                if (bus1.o_mismatch_vld !== x.mm_vld || bus1.o_mismatch_addr !== x.mm_addr)
                    $display("FAIL mm1: got %b/%0d expected %b/%0d", bus1.o_mismatch_vld,
                             bus1.o_mismatch_addr, x.mm_vld, x.mm_addr);
                else chk_pass++;
`endif
            end
            if (bus3.o_done === 1'b1 && !got3) begin
                got3 = 1'b1;
                x = sb3.pop_front();
                chk_total++;
                if (cyc - c0 !== x.lat) $display("FAIL lat3: got %0d expected %0d", cyc - c0, x.lat);
                else chk_pass++;
                chk_total++;
                if (bus3.o_fail !== x.fail) $display("FAIL fail3: got %b expected %b", bus3.o_fail, x.fail);
                else chk_pass++;
                chk_total++;
                if (bus3.o_busy !== 1'b0) $display("FAIL busy3_at_done: got %b expected 0", bus3.o_busy);
                else chk_pass++;
`ifdef MEM_COMPARE_FIRST_MISMATCH_EN
                chk_total++;
                if (bus3.o_mismatch_vld !== x.mm_vld || bus3.o_mismatch_addr !== x.mm_addr)
                    $display("FAIL mm3: got %b/%0d expected %b/%0d", bus3.o_mismatch_vld,
                             bus3.o_mismatch_addr, x.mm_vld, x.mm_addr);
                else chk_pass++;
`endif
            end
        end
        if (!got1) begin
            chk_total++;
            $display("FAIL done1_timeout: got no o_done expected one within 60 cycles");
            if (sb1.size() > 0) void'(sb1.pop_front());
        end
        if (!got3) begin
            chk_total++;
            $display("FAIL done3_timeout: got no o_done expected one within 60 cycles");
            if (sb3.size() > 0) void'(sb3.pop_front());
        end

        chk_total++;
        if (seen1.size() !== n || seen3.size() !== n)
            $display("FAIL addr_count: got %0d/%0d expected %0d", seen1.size(), seen3.size(), n);
        else begin
            chk_pass++;
            for (int i = 0; i < n; i++) begin
                chk_total++;
                if (seen1[i] !== exp_addr[i] || seen3[i] !== exp_addr[i])
                    $display("FAIL addr_seq[%0d]: got %0d/%0d expected %0d", i, seen1[i], seen3[i], exp_addr[i]);
                else chk_pass++;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] obs1, obs3;
        obs1 = {bus1.o_mem_in_addr, bus1.o_mem_in_en, bus1.o_busy, bus1.o_fail, bus1.o_done};
        obs3 = {bus3.o_mem_in_addr, bus3.o_mem_in_en, bus3.o_busy, bus3.o_fail, bus3.o_done};
        chk_total++;
        if (obs1 !== 8'h00) $display("FAIL reset1_outputs: got %h expected 00", obs1);
        else chk_pass++;
        chk_total++;
        if (obs3 !== 8'h00) $display("FAIL reset3_outputs: got %h expected 00", obs3);
        else chk_pass++;
    endtask

    task automatic test_equal();
        fill_equal();
        run_op(4'd2, 4'd5, '1, 1'b0);
    endtask

    task automatic test_mismatch();
        fill_equal();
        mem2[3] = mem1[3] ^ 32'h1;
        run_op(4'd2, 4'd5, '1, 1'b0);
    endtask

    task automatic test_wrap();
        fill_equal();
        mem2[0] = mem1[0] ^ 32'h0001_0000;
        mem2[1] = mem1[1] ^ 32'h4;
        run_op(4'd14, 4'd1, '1, 1'b0);
    endtask

    task automatic test_last_mask();
        fill_equal();
        mem2[7] = mem1[7] ^ 32'h8000_0000;
        run_op(4'd7, 4'd7, 32'h7FFF_FFFF, 1'b0);
        run_op(4'd7, 4'd7, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_start_ignored();
        fill_equal();
        mem2[5] = mem1[5] ^ 32'h0000_0100;
        run_op(4'd2, 4'd5, '1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int done_seen;
        logic [7:0] obs1, obs3;
        fill_equal();
        mem2[4] = mem1[4] ^ 32'h2;
        @(negedge clk);
        drive_req(1'b1, 4'd2, 4'd9, '1);
        @(posedge clk);
        @(negedge clk);
        drive_req(1'b0, 4'd2, 4'd9, '1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        obs1 = {bus1.o_mem_in_addr, bus1.o_mem_in_en, bus1.o_busy, bus1.o_fail, bus1.o_done};
        obs3 = {bus3.o_mem_in_addr, bus3.o_mem_in_en, bus3.o_busy, bus3.o_fail, bus3.o_done};
        chk_total++;
        if (obs1 !== 8'h00) $display("FAIL midrst1_outputs: got %h expected 00", obs1);
        else chk_pass++;
        chk_total++;
        if (obs3 !== 8'h00) $display("FAIL midrst3_outputs: got %h expected 00", obs3);
        else chk_pass++;
        done_seen = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus1.o_done === 1'b1 || bus3.o_done === 1'b1) done_seen++;
        end
        chk_total++;
        if (done_seen !== 0) $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen);
        else chk_pass++;
        fill_equal();
        run_op(4'd3, 4'd6, '1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] = $urandom;
                mem2[i] = ($urandom_range(0, 3) == 0) ? (mem1[i] ^ (32'h1 << $urandom_range(0, 31))) : mem1[i];
            end
            run_op(AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
                   $urandom, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_req(1'b0, '0, '0, '0);
        fill_equal();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_equal();
        test_mismatch();
        test_wrap();
        test_last_mask();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", chk_pass, chk_total);
        $finish;
    end

endmodule

// File: doc/mem_compare_pipe.md
MEM_COMPARE_PIPE -- requirements
Module: mem_compare_pipe

Interface
REQ-001 Parameter WIDTH, default 32: bits per compared word.
REQ-002 Parameter MAX_MEM_DEPTH, default 16: words per memory; AW = CLOG2(MAX_MEM_DEPTH).
REQ-003 Parameter RD_LAT, default 1, legal 1..4: cycles from address/enable to valid read data.
REQ-004 i_clk  in  1  single clock; all logic on rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  start request; sampled only in S_IDLE.
REQ-007 i_start_addr / i_end_addr  in  AW each  first and last word address (inclusive); sampled with i_start.
REQ-008 i_last_mask  in  WIDTH  bit mask applied to the last word only; sampled with i_start.
REQ-009 o_mem_in_addr  out  AW  shared read address to both memories.
REQ-010 o_mem_in_en  out  1  read enable to both memories.
REQ-011 i_mem_in_1 / i_mem_in_2  in  WIDTH each  read data, valid RD_LAT cycles after the enabled address.
REQ-012 o_busy  out  1  high from start acceptance until o_done.
REQ-013 o_fail  out  1  1 = mismatch found; valid while o_done=1 and held until next accepted start.
REQ-014 o_done  out  1  one-cycle completion pulse.

Function
REQ-015 States: S_IDLE, S_ISSUE, S_DRAIN, S_DONE; reset state S_IDLE.
REQ-016 S_IDLE: i_start=1 -> latch addresses and mask, set o_mem_in_addr=i_start_addr, clear o_fail, go to S_ISSUE.
REQ-017 S_ISSUE: o_mem_in_en=1 every cycle; one address per cycle, incrementing by 1 modulo 2^AW.
REQ-018 Word count N = ((i_end_addr - i_start_addr) mod 2^AW) + 1; start==end gives N=1; end<start wraps through 0 and does not stop at MAX_MEM_DEPTH.
REQ-019 After the enable for address end, go to S_DRAIN with o_mem_in_en=0.
REQ-020 An RD_LAT-deep valid/last shift register tags each issued read; a compare occurs only on a tagged-valid cycle.
REQ-021 Compare term = (i_mem_in_1 ^ i_mem_in_2) & m, where m = i_last_mask for the last word and all-ones otherwise; OR-reduce it into a sticky accumulator.
REQ-022 Constant time: no early exit on mismatch; the cycle count depends only on N and RD_LAT, never on data.
REQ-023 On the last tagged compare, o_fail <= accumulator | current term and o_done <= 1 on the same edge, then S_DONE -> S_IDLE.
REQ-024 Latency: o_done is high exactly N+RD_LAT cycles after the edge that accepted i_start; o_busy deasserts on that same edge.
REQ-025 i_start outside S_IDLE is ignored, with no effect on the addresses, mask or accumulator.
REQ-026 o_mem_in_en is combinational from the state; o_mem_in_addr holds its last value when idle.

Reset
REQ-027 i_rst=1 asynchronously forces S_IDLE, o_mem_in_addr=0, o_mem_in_en=0, o_busy=0, o_fail=0, o_done=0, and clears the accumulator and valid pipeline.
REQ-028 Reset mid-operation aborts the operation with no o_done pulse; the next i_start after reset release starts a clean operation.

Configuration
REQ-029 Macro MEM_COMPARE_FIRST_MISMATCH_EN.
REQ-030 Macro defined: adds o_mismatch_addr (out, AW) and o_mismatch_vld (out, 1).
- Captures the address of the first word whose compare term is nonzero.
- Later mismatches do not overwrite it; timing is unchanged.
- Both outputs are valid with o_done, cleared on start acceptance, and reset to 0.
REQ-031 Macro undefined: these ports and their registers are absent; all other behaviour is identical.

Verification
REQ-032 RD_LAT=1, start=2, end=5, memories equal -> addresses 2,3,4,5 issued on consecutive cycles with en=1; o_done after 5 cycles; o_fail=0.
REQ-033 Same range, mem2[3] differs in bit 0 -> o_fail=1; o_done after 5 cycles (same as REQ-032); with the macro defined, o_mismatch_addr=3.
REQ-034 MAX_MEM_DEPTH=16, start=14, end=1 -> addresses 14,15,0,1 issued (N=4); RD_LAT=3 gives o_done after 7 cycles.
REQ-035 start=end=7, words differ only in bit 31, i_last_mask=32'h7FFFFFFF -> o_fail=0; with mask all-ones -> o_fail=1.
REQ-036 i_rst pulsed 2 cycles after start -> no o_done pulse, all outputs 0.
- i_start pulsed again while busy in a separate run -> ignored, with no change to the address sequence.
